// File: rtl/config_chain_loader_if.sv
//------------------------------------------------------------------------------
// Module      : config_chain_loader_if
// Description : Host word handshake (valid/ready) carrying configuration words
//               into the configuration chain loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface config_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;   // config word, bit 0 shifted first
  logic              cfg_valid;  // cfg_data is valid
  logic              cfg_ready;  // loader takes the word this cycle

  // Host / bitstream source side
  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  // Loader side
  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

`default_nettype wire

// File: rtl/config_chain_loader.sv
//------------------------------------------------------------------------------
// Module      : config_chain_loader
// Description : Sequences the serial fabric configuration chain. Takes config
//               words from the host, shifts them LSB-first onto prog_in with a
//               registered prog_clk, then drops prog_en to commit the chain.
//               Optional feature macro: CFG_CRC_EN (CRC-8 over shifted bits,
//               adds crc_expect / crc / crc_ok ports).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module config_chain_loader #(
  parameter int CHAIN_LEN = 48,  // prog_clk rising edges per load
  parameter int WORD_W    = 8,   // host word width
  parameter int CLK_DIV   = 1    // clk cycles per prog_clk phase, >= 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  config_chain_loader_if.slave        cfg,
  output logic                        prog_clk,
  output logic                        prog_en,
  output logic                        prog_in,
  input  logic                        prog_out,
  output logic                        busy,
  output logic                        done
`ifdef CFG_CRC_EN
  ,
  input  logic [7:0]                  crc_expect,
  output logic [7:0]                  crc,
  output logic                        crc_ok
`endif
);

  localparam int c_bl_w  = $clog2(CHAIN_LEN + 1);
  localparam int c_wb_w  = $clog2(WORD_W + 1);
  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_bl_w-1:0]  c_chain_len = c_bl_w'(CHAIN_LEN);
  localparam logic [c_bl_w-1:0]  c_bl_one    = c_bl_w'(1);
  localparam logic [c_wb_w-1:0]  c_wb_one    = c_wb_w'(1);
  localparam logic [c_wb_w-1:0]  c_word_w    = c_wb_w'(WORD_W);
  localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  // Every output is a flop so the chain never sees decode glitches
  logic                r_prog_clk,  w_prog_clk_nx;
  logic                r_prog_en,   w_prog_en_nx;
  logic                r_prog_in,   w_prog_in_nx;
  logic                r_cfg_ready, w_cfg_ready_nx;
  logic                r_busy,      w_busy_nx;
  logic                r_done,      w_done_nx;

  logic [WORD_W-1:0]   r_shreg,     w_shreg_nx;
  logic [WORD_W-1:0]   w_shreg_shift;
  logic [c_bl_w-1:0]   r_bits_left, w_bits_left_nx;
  logic [c_wb_w-1:0]   r_word_bits, w_word_bits_nx;
  logic [c_div_w-1:0]  r_div_cnt,   w_div_cnt_nx;
  logic [c_wb_w-1:0]   w_take;

  logic                w_rise;       // prog_clk goes high at the coming edge
  logic                w_start_acc;  // start accepted at the coming edge
  logic                w_unused;

  // Bits to take from the next word: the final word may be only partly used
  always_comb begin
    w_take = c_word_w;
    if (int'(r_bits_left) < WORD_W)
      w_take = c_wb_w'(r_bits_left);
  end

  // Shift register contents once the current bit has been clocked out
  assign w_shreg_shift = r_shreg >> 1;

  // Next-state and next-output decode
  always_comb begin
    w_state_nx     = r_state;
    w_prog_clk_nx  = r_prog_clk;
    w_prog_en_nx   = r_prog_en;
    w_prog_in_nx   = r_prog_in;
    w_cfg_ready_nx = 1'b0;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_shreg_nx     = r_shreg;
    w_bits_left_nx = r_bits_left;
    w_word_bits_nx = r_word_bits;
    w_div_cnt_nx   = r_div_cnt;
    w_rise         = 1'b0;
    w_start_acc    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx     = ST_FETCH;
          w_start_acc    = 1'b1;
          w_busy_nx      = 1'b1;
          w_prog_en_nx   = 1'b1;
          w_prog_clk_nx  = 1'b0;
          w_prog_in_nx   = 1'b0;
          w_cfg_ready_nx = 1'b1;
          w_bits_left_nx = c_chain_len;
          w_word_bits_nx = '0;
          w_div_cnt_nx   = '0;
        end
      end

      ST_FETCH: begin
        // A stalled host simply holds us here with prog_clk low
        w_cfg_ready_nx = 1'b1;
        if (cfg.cfg_valid) begin
          w_state_nx     = ST_SHIFT;
          w_cfg_ready_nx = 1'b0;
          w_shreg_nx     = cfg.cfg_data;
          w_word_bits_nx = w_take;
          w_prog_in_nx   = cfg.cfg_data[0];
          w_div_cnt_nx   = '0;
        end
      end

      ST_SHIFT: begin
        if (r_div_cnt != c_div_last) begin
          w_div_cnt_nx = r_div_cnt + c_div_w'(1);
        end else begin
          w_div_cnt_nx = '0;
          if (!r_prog_clk) begin
            // End of low phase: rising edge, prog_in already stable
            w_prog_clk_nx = 1'b1;
            w_rise        = 1'b1;
          end else begin
            // End of high phase: bit consumed, return clock low
            w_prog_clk_nx  = 1'b0;
            w_shreg_nx     = w_shreg_shift;
            w_bits_left_nx = (r_bits_left != '0) ? (r_bits_left - c_bl_one) : r_bits_left;
            w_word_bits_nx = (r_word_bits != '0) ? (r_word_bits - c_wb_one) : r_word_bits;
            if (r_bits_left == c_bl_one) begin
              w_state_nx = ST_COMMIT;
            end else if (r_word_bits == c_wb_one) begin
              w_state_nx     = ST_FETCH;
              w_cfg_ready_nx = 1'b1;
            end else begin
              w_prog_in_nx = w_shreg_shift[0];
            end
          end
        end
      end

      ST_COMMIT: begin
        // One quiet cycle with prog_clk low, then the commit edge on prog_en
        w_state_nx   = ST_DONE;
        w_prog_en_nx = 1'b0;
        w_done_nx    = 1'b1;
      end

      ST_DONE: begin
        w_state_nx   = ST_IDLE;
        w_busy_nx    = 1'b0;
        w_prog_in_nx = 1'b0;
      end

      default: begin
        w_state_nx    = ST_IDLE;
        w_busy_nx     = 1'b0;
        w_prog_en_nx  = 1'b0;
        w_prog_clk_nx = 1'b0;
        w_prog_in_nx  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nx;
  end

  // Registered outputs and datapath; reset drops prog_en, committing partial data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_clk  <= 1'b0;
      r_prog_en   <= 1'b0;
      r_prog_in   <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_shreg     <= '0;
      r_bits_left <= '0;
      r_word_bits <= '0;
      r_div_cnt   <= '0;
    end else begin
      r_prog_clk  <= w_prog_clk_nx;
      r_prog_en   <= w_prog_en_nx;
      r_prog_in   <= w_prog_in_nx;
      r_cfg_ready <= w_cfg_ready_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_shreg     <= w_shreg_nx;
      r_bits_left <= w_bits_left_nx;
      r_word_bits <= w_word_bits_nx;
      r_div_cnt   <= w_div_cnt_nx;
    end
  end

  assign prog_clk      = r_prog_clk;
  assign prog_en       = r_prog_en;
  assign prog_in       = r_prog_in;
  assign cfg.cfg_ready = r_cfg_ready;
  assign busy          = r_busy;
  assign done          = r_done;

`ifdef CFG_CRC_EN
  logic [7:0] r_crc;
  logic       r_crc_ok;

  // CRC-8 (poly 0x07, MSB-first) over each bit as the chain clocks it in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc    <= 8'h00;
      r_crc_ok <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_crc    <= 8'h00;
        r_crc_ok <= 1'b0;
      end else if (w_rise) begin
        r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ r_prog_in) ? 8'h07 : 8'h00);
      end
      // Last rising edge is long past by COMMIT, so the compare lands in DONE
      if (r_state == ST_COMMIT)
        r_crc_ok <= (r_crc == crc_expect);
    end
  end

  assign crc    = r_crc;
  assign crc_ok = r_crc_ok;
`endif

  // The chain tail return is not consumed by the loader itself
  assign w_unused = ^{prog_out, w_rise, w_start_acc};

endmodule

`default_nettype wire
